riscv_run_ctrl: RTL and testbench

Run/load sequencer for the single-cycle RISC-V core. It loads program words into the core's instruction memory through a valid/ready channel, driving the core's `instruction_write`/`instruction_addr`/`instruction_data` port. It then enables the core PC (`run_pc`) for exactly a programmed number of cycles, and reports completion. It sits between the AXI4-Lite register slave and the core.

---
 rtl/riscv_run_ctrl.sv | 96 +++++++++
 tb/tb_riscv_run_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// Run/load sequencer for the single-cycle RISC-V core: streams program words
// into instruction memory, then enables the PC for a programmed cycle count.
module riscv_run_ctrl #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load_start,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [31:0]       i_load_data,
  input  logic              i_load_last,
  input  logic              i_run,
  input  logic [CNT_W-1:0]  i_num_cycle,
  input  logic              i_abort,
  output logic              instruction_write,
  output logic [ADDR_W-1:0] instruction_addr,
  output logic [31:0]       instruction_data,
  output logic              run_pc,
  output logic              o_idle,
  output logic              o_running,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              beat;

  // Status and enables are decoded from the state register alone, so an
  // asynchronous reset drops run_pc and load_ready without waiting for an edge.
  assign o_idle       = (state == S_IDLE);
  assign o_load_ready = (state == S_LOAD);
  assign run_pc       = (state == S_RUN);
  assign o_running    = (state == S_RUN);
  assign o_done       = (state == S_DONE);
  assign o_cycle_cnt  = cycle_cnt;

  assign beat    = (state == S_LOAD) && i_load_valid;
  assign cnt_nxt = cycle_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      addr_cnt          <= '0;
      num_q             <= '0;
      cycle_cnt         <= '0;
      instruction_write <= 1'b0;
      instruction_addr  <= '0;
      instruction_data  <= '0;
    end else begin
      instruction_write <= 1'b0;
      // A beat is written even when abort lands in the same cycle.
      if (beat) begin
        instruction_write <= 1'b1;
        instruction_addr  <= addr_cnt;
        instruction_data  <= i_load_data;
        addr_cnt          <= addr_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (i_load_start) begin
            state    <= S_LOAD;
            addr_cnt <= '0;
          end else if (i_run) begin
            num_q     <= i_num_cycle;
            cycle_cnt <= '0;
            state     <= (i_num_cycle == '0) ? S_DONE : S_RUN;
          end
        end
        S_LOAD: begin
          if (i_abort)
            state <= S_DONE;
          else if (beat && i_load_last)
            state <= S_IDLE;
        end
        S_RUN: begin
          // The abort cycle is still a run cycle, so it is counted too.
          if (cycle_cnt != num_q)
            cycle_cnt <= cnt_nxt;
          if (i_abort || cnt_nxt == num_q)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: vector table of runs, random runs and
// loads against a transaction-level model, plus abort and reset corner cases.
module tb_riscv_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_load_start, i_load_valid, i_load_last, i_run, i_abort;
  logic [31:0] i_load_data;
  logic [31:0] i_num_cycle;
  logic        o_load_ready, instruction_write, run_pc, o_idle, o_running, o_done;
  logic [7:0]  instruction_addr;
  logic [31:0] instruction_data, o_cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  riscv_run_ctrl #(.CNT_W(32), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_load_start(i_load_start), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
    .i_load_data(i_load_data), .i_load_last(i_load_last),
    .i_run(i_run), .i_num_cycle(i_num_cycle), .i_abort(i_abort),
    .instruction_write(instruction_write), .instruction_addr(instruction_addr),
    .instruction_data(instruction_data), .run_pc(run_pc),
    .o_idle(o_idle), .o_running(o_running), .o_done(o_done), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    int unsigned abort_at;  // 0 = no abort, else abort on that run cycle
    int unsigned exp_runs;
    int unsigned exp_cnt;
  } run_vec_t;

  run_vec_t    tbl[6];
  logic [31:0] prog[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_load_start = 0; i_load_valid = 0; i_load_last = 0; i_run = 0; i_abort = 0;
    i_load_data = 0; i_num_cycle = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_ready"}, o_load_ready, 0);
    chk({tag, "_wr"}, instruction_write, 0);
    chk({tag, "_addr"}, instruction_addr, 0);
    chk({tag, "_data"}, instruction_data, 0);
    chk({tag, "_run_pc"}, run_pc, 0);
    chk({tag, "_running"}, o_running, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_cnt"}, o_cycle_cnt, 0);
  endtask

  // Issue a run from IDLE and follow it to DONE and back to IDLE.
  task automatic run_seq(input int unsigned n, input int unsigned abort_at,
                         input int unsigned exp_runs, input int unsigned exp_cnt,
                         input string name);
    int unsigned runs = 0;
    bit seen_done = 0;
    bit trace_ok = 1;
    i_num_cycle = n;
    i_run = 1;
    tick();
    i_num_cycle = $urandom;  // must not disturb the latched count
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      i_run = 0; i_abort = 0;
      if (run_pc) begin
        runs++;
        if (o_cycle_cnt != runs - 1 || !o_running || o_idle) trace_ok = 0;
        i_run = 1'($urandom_range(0, 1));
        if (runs == abort_at) i_abort = 1;
        tick();
      end else if (o_done) begin
        seen_done = 1;
      end else begin
        break;
      end
    end
    chk({name, "_done_seen"}, seen_done, 1);
    chk({name, "_runs"}, runs, exp_runs);
    chk({name, "_trace"}, trace_ok, 1);
    chk({name, "_cnt_done"}, o_cycle_cnt, exp_cnt);
    i_run = 0; i_abort = 0;
    tick();
    chk({name, "_idle_after"}, o_idle, 1);
    chk({name, "_done_pulse"}, o_done, 0);
    tick();
    chk({name, "_cnt_held"}, o_cycle_cnt, exp_cnt);
  endtask

  // Load n words with random gaps; model: beat k lands at address k mod 256.
  task automatic load_seq(input int n, input int gap_pct, input bit with_run,
                          input bit fixed, input string name);
    int k = 0;
    bit beat;
    logic [31:0] d;
    bit ok = 1;
    int writes = 0;
    i_load_start = 1;
    i_run = with_run;
    i_num_cycle = 7;
    tick();
    i_load_start = 0; i_run = 0;
    chk({name, "_ready_on"}, o_load_ready, 1);
    chk({name, "_no_run"}, run_pc, 0);
    for (int cyc = 0; cyc < 4000 && k < n; cyc++) begin
      beat = ($urandom_range(0, 99) >= gap_pct) || fixed;
      d = (fixed && k < 4) ? prog[k] : $urandom;
      i_load_valid = beat;
      i_load_data  = d;
      i_load_last  = (k == n - 1);
      i_run        = 1'($urandom_range(0, 1));
      i_load_start = 1'($urandom_range(0, 1));
      if (!o_load_ready) ok = 0;
      tick();
      if (instruction_write !== beat) ok = 0;
      if (beat) begin
        writes++;
        if (instruction_addr !== 8'(k % 256) || instruction_data !== d) ok = 0;
        if (k == 256) chk({name, "_wrap_addr"}, instruction_addr, 0);
        k++;
      end
    end
    clear_inputs();
    chk({name, "_beats"}, writes, n);
    chk({name, "_stream"}, ok, 1);
    chk({name, "_idle_after"}, o_idle, 1);
    chk({name, "_ready_off"}, o_load_ready, 0);
    tick();
    chk({name, "_wr_off"}, instruction_write, 0);
  endtask

  initial begin
    int unsigned rn, ra, re;
    tbl[0] = '{n: 10,  abort_at: 0, exp_runs: 10, exp_cnt: 10};
    tbl[1] = '{n: 0,   abort_at: 0, exp_runs: 0,  exp_cnt: 0};
    tbl[2] = '{n: 1,   abort_at: 0, exp_runs: 1,  exp_cnt: 1};
    tbl[3] = '{n: 100, abort_at: 3, exp_runs: 3,  exp_cnt: 3};
    tbl[4] = '{n: 5,   abort_at: 5, exp_runs: 5,  exp_cnt: 5};
    tbl[5] = '{n: 2,   abort_at: 1, exp_runs: 1,  exp_cnt: 1};
    prog[0] = 32'h00500093; prog[1] = 32'h00308113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000013;

    clear_inputs();
    reset_n = 0;
    #12;
    check_reset_vals("reset");
    i_abort = 1;  // ignored in IDLE
    @(negedge clk);
    reset_n = 1;
    tick();
    i_abort = 0;
    chk("abort_idle_ignored", o_idle, 1);

    load_seq(4, 0, 0, 1, "load4");

    for (int i = 0; i < 6; i++)
      run_seq(tbl[i].n, tbl[i].abort_at, tbl[i].exp_runs, tbl[i].exp_cnt, $sformatf("tbl%0d", i));

    load_seq(257, 30, 1, 0, "load257");

    // Abort during LOAD: the beat in the abort cycle is still written.
    i_load_start = 1; tick(); i_load_start = 0;
    i_load_valid = 1; i_load_data = 32'hAAAA0000; tick();
    i_load_data = 32'hAAAA0001; tick();
    i_load_data = 32'hAAAA0002; i_abort = 1; tick();
    clear_inputs();
    chk("ld_abort_wr", instruction_write, 1);
    chk("ld_abort_addr", instruction_addr, 2);
    chk("ld_abort_data", instruction_data, 32'hAAAA0002);
    chk("ld_abort_done", o_done, 1);
    chk("ld_abort_ready", o_load_ready, 0);
    tick();
    chk("ld_abort_idle", o_idle, 1);
    chk("ld_abort_wr_off", instruction_write, 0);

    // Randomized runs and loads against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_seq(int'($urandom_range(1, 12)), 40, 1'($urandom_range(0, 1)), 0, $sformatf("rl%0d", i));
      end else begin
        rn = $urandom_range(0, 40);
        ra = ($urandom_range(0, 1) != 0) ? $urandom_range(1, rn + 3) : 0;
        re = (ra != 0 && ra < rn) ? ra : rn;
        run_seq(rn, ra, re, re, $sformatf("rr%0d", i));
      end
    end

    // Reset in the 5th cycle of a 20-cycle run.
    i_num_cycle = 20; i_run = 1; tick(); i_run = 0;
    repeat (4) tick();
    chk("rst_run_pre_pc", run_pc, 1);
    chk("rst_run_pre_cnt", o_cycle_cnt, 4);
    #2 reset_n = 0;
    #1;
    check_reset_vals("rst_run");
    @(negedge clk);
    reset_n = 1;
    run_seq(2, 0, 2, 2, "post_rst");

    // Reset while a write strobe is up.
    i_load_start = 1; tick(); i_load_start = 0;
    i_load_valid = 1; i_load_data = 32'h12345678; tick();
    clear_inputs();
    chk("rst_ld_wr_pre", instruction_write, 1);
    #2 reset_n = 0;
    #1;
    check_reset_vals("rst_ld");
    @(negedge clk);
    reset_n = 1;
    load_seq(3, 0, 0, 0, "post_rst_ld");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
